// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned LINE_W  = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned NUM_W   = 32;
  localparam int unsigned PRESS_W = 2;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [PRESS_W-1:0] PRESS_NONE  = 2'b00;
  localparam logic [PRESS_W-1:0] PRESS_DIGIT = 2'b01;
  localparam logic [PRESS_W-1:0] PRESS_FUNC  = 2'b10;

  // Indexed [row][col]; A-D live in column 3, row 3 is *, 0, #, D.
  localparam logic [CODE_W-1:0] KEY_MAP [LINE_W][LINE_W] = '{
    '{4'd1,  4'd2, 4'd3,  4'd10},
    '{4'd4,  4'd5, 4'd6,  4'd11},
    '{4'd7,  4'd8, 4'd9,  4'd12},
    '{4'd14, 4'd0, 4'd15, 4'd13}
  };

  function automatic logic is_digit(input logic [CODE_W-1:0] code);
    return code <= CODE_W'(9);
  endfunction

  function automatic logic [PRESS_W-1:0] press_class(input logic [CODE_W-1:0] code);
    return is_digit(code) ? PRESS_DIGIT : PRESS_FUNC;
  endfunction

  // Exactly one row pulled low; zero or several low rows read as no key.
  function automatic logic single_low(input logic [LINE_W-1:0] rows);
    return $countones(~rows) == 1;
  endfunction

  function automatic logic [IDX_W-1:0] low_index(input logic [LINE_W-1:0] rows);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(LINE_W); i++) begin
      if (!rows[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pins plus decoded-key outputs; master is the scanner, slave its surroundings.
interface keypad_scan_if;
  import keypad_pkg::*;

  logic [LINE_W-1:0]  row_n;
  logic [LINE_W-1:0]  col_n;
  logic [CODE_W-1:0]  key_code;
  logic               key_valid;
  logic [NUM_W-1:0]   number;
  logic [PRESS_W-1:0] pressed;
  logic               key_held;

  modport master (
    input  row_n,
    output col_n, key_code, key_valid, number, pressed, key_held
  );

  modport slave (
    output row_n,
    input  col_n, key_code, key_valid, number, pressed, key_held
  );

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines; resets to all-ones (no key).
module keypad_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column scan, press/release debounce, key decode.
// Build option KEY_REPEAT_EN: auto-repeat while a key stays held.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master bus
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT + 1);
`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_W = $clog2(4 * DEBOUNCE_CNT);
`endif

  logic [LINE_W-1:0]  row_s;
  logic [DIV_W-1:0]   div_cnt_q;
  logic               tick_c;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   col_idx_q, col_idx_d;
  logic [LINE_W-1:0]  row_lat_q, row_lat_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [LINE_W-1:0]  col_n_q;
  logic [CODE_W-1:0]  key_code_q, key_code_d;
  logic               key_valid_q, key_valid_d;
  logic [NUM_W-1:0]   number_q, number_d;
  logic [PRESS_W-1:0] pressed_q, pressed_d;
  logic               key_held_q, key_held_d;
  logic [CODE_W-1:0]  accept_code_c;
`ifdef KEY_REPEAT_EN
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic               rep_pend_q, rep_pend_d;
`endif

  keypad_sync #(.WIDTH(LINE_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.row_n),
    .q   (row_s)
  );

  // Free-running sample divider; tick on the last count.
  assign tick_c = (div_cnt_q == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)         div_cnt_q <= '0;
    else if (tick_c) div_cnt_q <= '0;
    else             div_cnt_q <= div_cnt_q + DIV_W'(1);
  end

  assign accept_code_c = KEY_MAP[low_index(row_lat_q)][col_idx_q];

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_lat_d   = row_lat_q;
    deb_cnt_d   = deb_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    number_d    = number_q;
    pressed_d   = pressed_q;
    key_held_d  = key_held_q;
`ifdef KEY_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_pend_d  = 1'b0;
    // A repeat drops pressed for one cycle; restore it here.
    if (rep_pend_q) pressed_d = press_class(key_code_q);
`endif
    if (tick_c) begin
      case (state_q)
        SCAN: begin
          if (single_low(row_s)) begin
            row_lat_d = row_s;
            deb_cnt_d = DEB_W'(1);
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + IDX_W'(1);
          end
        end
        DEBOUNCE: begin
          if (row_s == row_lat_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CNT - 1)) begin
              state_d     = HELD;
              key_code_d  = accept_code_c;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              pressed_d   = press_class(accept_code_c);
              if (is_digit(accept_code_c)) number_d = NUM_W'(accept_code_c);
`ifdef KEY_REPEAT_EN
              rep_cnt_d   = '0;
`endif
            end else begin
              deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
          end else begin
            state_d   = SCAN;
            col_idx_d = col_idx_q + IDX_W'(1);
          end
        end
        HELD: begin
          if (row_s == '1) begin
            deb_cnt_d = DEB_W'(1);
            state_d   = RELEASE;
          end
`ifdef KEY_REPEAT_EN
          else if (rep_cnt_q == REP_W'(4 * DEBOUNCE_CNT - 1)) begin
            key_valid_d = 1'b1;
            key_code_d  = key_code_q;
            if (is_digit(key_code_q)) number_d = NUM_W'(key_code_q);
            pressed_d   = PRESS_NONE;
            rep_pend_d  = 1'b1;
            rep_cnt_d   = REP_W'(2 * DEBOUNCE_CNT);
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
`endif
        end
        RELEASE: begin
          if (row_s == '1) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CNT - 1)) begin
              state_d    = SCAN;
              col_idx_d  = col_idx_q + IDX_W'(1);
              key_held_d = 1'b0;
              pressed_d  = PRESS_NONE;
            end else begin
              deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      col_idx_q   <= '0;
      row_lat_q   <= '1;
      deb_cnt_q   <= '0;
      col_n_q     <= 4'b1110;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      number_q    <= '0;
      pressed_q   <= PRESS_NONE;
      key_held_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_lat_q   <= row_lat_d;
      deb_cnt_q   <= deb_cnt_d;
      col_n_q     <= ~(LINE_W'(1) << col_idx_d);
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      number_q    <= number_d;
      pressed_q   <= pressed_d;
      key_held_q  <= key_held_d;
`ifdef KEY_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_pend_q  <= rep_pend_d;
`endif
    end
  end

  assign bus.col_n     = col_n_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.number    = number_q;
  assign bus.pressed   = pressed_q;
  assign bus.key_held  = key_held_q;

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad, debounces presses and decodes them into a key code.
- Outputs number/pressed in the format the calculator operand reader consumes: that reader captures on a rising edge of pressed.
- Sits between the board keypad pins and the operand-entry stage.
- Also outputs a one-cycle key_valid strobe for other consumers, e.g. the stopwatch control.

Parameters:
- SCAN_DIV, 1000, clk cycles each column is driven before its rows are sampled (min 4).
- DEBOUNCE_CNT, 8, consecutive identical samples required to accept a press or a release (min 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- row_n  in  4  keypad rows, active-low, pulled up, asynchronous to clk.
- col_n  out  4  column drive, one-hot low.
- key_code  out  4  decoded code of last accepted key.
- key_valid  out  1  one-cycle pulse on acceptance.
- number  out  32  key_code zero-extended when it is a digit (0-9); otherwise holds its previous value.
- pressed  out  2  2'b01 = digit held, 2'b10 = function key held, 2'b00 = idle.
- key_held  out  1  high from acceptance until release is accepted.

Behaviour:
- row_n passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Sample tick: a counter 0..SCAN_DIV-1 runs continuously; the tick fires when the count = SCAN_DIV-1.
- Key map (row r, col c) -> code:
  - r0: 1, 2, 3, 10(A)
  - r1: 4, 5, 6, 11(B)
  - r2: 7, 8, 9, 12(C)
  - r3: 14(*), 0, 15(#), 13(D)
- Valid sample: exactly one row low. Zero or 2+ rows low counts as "no key" (ghosting rejected).
- FSM states:
  - SCAN: on each tick, if the sample is valid, latch col/row, set deb_cnt=1 and go to DEBOUNCE. Otherwise rotate col_n left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - DEBOUNCE: col frozen. On each tick:
    - Sample equals the latched row: deb_cnt++. On reaching DEBOUNCE_CNT, go to HELD in the same cycle that key_valid pulses.
    - Sample differs: go to SCAN, rotate column.
  - HELD: col frozen. A tick with all rows high sets deb_cnt=1 and goes to RELEASE.
  - RELEASE: all-high tick: deb_cnt++; at DEBOUNCE_CNT go to SCAN and rotate column. A tick with any row low returns to HELD; no new key_valid.
- On acceptance, in one cycle:
  - key_code updated, key_valid=1.
  - number updated if digit.
  - key_held=1.
  - pressed set to 01 or 10.
- On release acceptance, in one cycle: key_held=0, pressed=00.
- Accept latency from a stable physical press in the sampled column: 2 sync cycles plus DEBOUNCE_CNT ticks.
- pressed is always exactly 00 between two accepted keys, so a downstream edge detector sees one rising edge per press.
- Reset (also mid-scan or mid-hold): state SCAN, col_n=1110, counters 0, key_code=0, key_valid=0, number=0, pressed=00, key_held=0. Synchronizer flops reset to 1111.
- Simultaneous tick and rst: rst wins.

Optional Feature:
- KEY_REPEAT_EN defined: in HELD, after 4*DEBOUNCE_CNT ticks the key repeats every 2*DEBOUNCE_CNT ticks. Each repeat:
  - key_valid pulses.
  - pressed drops to 00 for exactly one cycle, then returns to its code.
  - number/key_code are re-written with the same value.
- Not defined: HELD produces no further events until release.

Decomposition:
- Package keypad_pkg:
  - state enum (SCAN, DEBOUNCE, HELD, RELEASE).
  - PRESS_NONE/PRESS_DIGIT/PRESS_FUNC 2-bit constants.
  - key-map constant array [row][col] -> code.
  - function is_digit(code).
- One sub-module: keypad_sync (2-flop synchronizer, width 4, reset value all-ones). The FSM stays in keypad_scan.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
1. Hold row1 low only while col_n=1101 (key 5), release after 40 cycles -> one key_valid, key_code=5, number=5, pressed=01 until release accepted, then 00.
2. Press col3/row0 (A) after a prior digit 7 -> key_code=10, number stays 7, pressed=10.
3. Bounce: row toggles on alternate ticks for 5 ticks, then stable -> single key_valid only after 3 consecutive stable ticks; no pulse during bounce.
4. Rows 0 and 2 low simultaneously in one column -> no key_valid, col_n keeps rotating.
5. rst asserted in HELD while key held -> next cycle pressed=00, key_held=0, col_n=1110. After rst drops with the key still held, exactly one new key_valid.
6. KEY_REPEAT_EN defined, key 9 held 100 ticks -> first repeat after 12 ticks in HELD, then every 6 ticks; each repeat gives pressed 01 -> 00 -> 01 with number=9.
